// File: rtl/usb_ep_status_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_status_arb_pkg
// Brief    : Shared constants and FSM state encoding for the EP status RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package usb_ep_status_arb_pkg;

    localparam int EPS_RD_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_ACK    = 2'd2
    } eps_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_eps_clr_seq.sv
`default_nettype none
// ============================================================================
// Module   : usb_eps_clr_seq
// Brief    : Zero-sweep address counter and busy flag; steps only in engine-idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module usb_eps_clr_seq
    import usb_ep_status_arb_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic          eng_busy,
    output logic          clr_busy,
    output logic [AW-1:0] sweep_addr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_busy   <= 1'b0;
            sweep_addr <= '0;
        end else if (!clr_busy) begin
            if (clr_req) begin
                clr_busy <= 1'b1;
            end
        end else if (!eng_busy) begin
            // The counter wraps to 0 on the last address, ready for the next sweep.
            sweep_addr <= sweep_addr + 1'b1;
            if (&sweep_addr) begin
                clr_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_ep_status_arb.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_status_arb
// Brief    : EP status RAM arbiter: engine > clear sweep > host bus (req/ack).
//            Macro USB_EPS_ARB_CLEAR_EN builds the whole-RAM zero sweep.
// Revision : 1.0 - initial release
// ============================================================================
module usb_ep_status_arb
    import usb_ep_status_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = EPS_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eng_read_0,
    input  logic          eng_zero_0,
    input  logic          eng_write_0,
    input  logic [AW-1:0] eng_addr_0,
    input  logic [DW-1:0] eng_wrdata_0,
    output logic [DW-1:0] eng_rddata_3,
    input  logic          hb_req,
    input  logic          hb_we,
    input  logic [AW-1:0] hb_addr,
    input  logic [DW-1:0] hb_wdata,
    output logic [DW-1:0] hb_rdata,
    output logic          hb_ack,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          ram_read_0,
    output logic          ram_zero_0,
    output logic          ram_write_0,
    output logic [AW-1:0] ram_addr_0,
    output logic [DW-1:0] ram_wrdata_0,
    input  logic [DW-1:0] ram_rddata_3
);

    logic          w_eng_busy;
    logic          w_host_issue;
    logic          w_sweep_wr;
    logic [AW-1:0] w_sweep_addr;
    eps_state_t    r_state;
    logic [RD_LAT-1:0] r_tag;
    logic          r_hb_ack;
    logic [DW-1:0] r_hb_rdata;

    assign w_eng_busy   = eng_read_0 | eng_zero_0 | eng_write_0;
    assign eng_rddata_3 = ram_rddata_3;
    assign hb_ack       = r_hb_ack;
    assign hb_rdata     = r_hb_rdata;

`ifdef USB_EPS_ARB_CLEAR_EN
    usb_eps_clr_seq #(
        .AW (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .eng_busy   (w_eng_busy),
        .clr_busy   (clr_busy),
        .sweep_addr (w_sweep_addr)
    );
`else
    logic w_unused_clr_req;
    assign w_unused_clr_req = clr_req;
    assign clr_busy         = 1'b0;
    assign w_sweep_addr     = '0;
`endif

    assign w_sweep_wr   = clr_busy & ~w_eng_busy;
    assign w_host_issue = (r_state == ST_IDLE) & hb_req & ~w_eng_busy & ~clr_busy;

    always_comb begin
        ram_read_0   = 1'b0;
        ram_zero_0   = 1'b0;
        ram_write_0  = 1'b0;
        ram_addr_0   = '0;
        ram_wrdata_0 = '0;
        if (w_eng_busy) begin
            ram_read_0   = eng_read_0;
            ram_zero_0   = eng_zero_0;
            ram_write_0  = eng_write_0;
            ram_addr_0   = eng_addr_0;
            ram_wrdata_0 = eng_wrdata_0;
        end else if (w_sweep_wr) begin
            ram_write_0  = 1'b1;
            ram_addr_0   = w_sweep_addr;
        end else if (w_host_issue) begin
            ram_read_0   = ~hb_we;
            ram_write_0  = hb_we;
            ram_addr_0   = hb_addr;
            ram_wrdata_0 = hb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tag      <= '0;
            r_hb_ack   <= 1'b0;
            r_hb_rdata <= '0;
        end else begin
            // The tag bit reaches the top exactly when the host's read data is on ram_rddata_3.
            r_tag    <= (r_tag << 1) | RD_LAT'(w_host_issue & ~hb_we);
            r_hb_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_host_issue) begin
                        if (hb_we) begin
                            r_state  <= ST_ACK;
                            r_hb_ack <= 1'b1;
                        end else begin
                            r_state  <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (r_tag[RD_LAT-1]) begin
                        r_hb_rdata <= ram_rddata_3;
                        r_state    <= ST_ACK;
                        r_hb_ack   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_status_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_ep_status_arb
// Brief    : Directed self-checking bench for usb_ep_status_arb with a 3-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_ep_status_arb;

    logic        clk;
    logic        rst;
    logic        eng_read_0, eng_zero_0, eng_write_0;
    logic [7:0]  eng_addr_0;
    logic [15:0] eng_wrdata_0, eng_rddata_3;
    logic        hb_req, hb_we, hb_ack;
    logic [7:0]  hb_addr;
    logic [15:0] hb_wdata, hb_rdata;
    logic        clr_req, clr_busy;
    logic        ram_read_0, ram_zero_0, ram_write_0;
    logic [7:0]  ram_addr_0;
    logic [15:0] ram_wrdata_0, ram_rddata_3;

    int n_chk  = 0;
    int n_fail = 0;

    usb_ep_status_arb dut (
        .clk          (clk),
        .rst          (rst),
        .eng_read_0   (eng_read_0),
        .eng_zero_0   (eng_zero_0),
        .eng_write_0  (eng_write_0),
        .eng_addr_0   (eng_addr_0),
        .eng_wrdata_0 (eng_wrdata_0),
        .eng_rddata_3 (eng_rddata_3),
        .hb_req       (hb_req),
        .hb_we        (hb_we),
        .hb_addr      (hb_addr),
        .hb_wdata     (hb_wdata),
        .hb_rdata     (hb_rdata),
        .hb_ack       (hb_ack),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .ram_read_0   (ram_read_0),
        .ram_zero_0   (ram_zero_0),
        .ram_write_0  (ram_write_0),
        .ram_addr_0   (ram_addr_0),
        .ram_wrdata_0 (ram_wrdata_0),
        .ram_rddata_3 (ram_rddata_3)
    );

    // RAM model: read data appears three cycles after the command cycle.
    logic [15:0] mem [0:255];
    logic [15:0] r_p0, r_p1, r_p2;
    always @(posedge clk) begin
        if (ram_write_0)     mem[ram_addr_0] <= ram_wrdata_0;
        else if (ram_zero_0) mem[ram_addr_0] <= 16'h0000;
        r_p0 <= ram_read_0 ? mem[ram_addr_0] : 16'hDEAD;
        r_p1 <= r_p0;
        r_p2 <= r_p1;
    end
    assign ram_rddata_3 = r_p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eng_wr(input logic [7:0] a, input logic [15:0] d);
        tick();
        eng_write_0 = 1'b1; eng_addr_0 = a; eng_wrdata_0 = d;
        tick();
        eng_write_0 = 1'b0;
    endtask

    task automatic host_rd(input logic [7:0] a, output logic [15:0] d, output int lat);
        tick();
        hb_req = 1'b1; hb_we = 1'b0; hb_addr = a;
        lat = 0;
        #1;
        while (!hb_ack && lat < 50) begin
            tick(); #1;
            lat++;
        end
        d = hb_rdata;
        tick();
        hb_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int          lat;
        rst = 1'b1; clr_req = 1'b0;
        eng_read_0 = 0; eng_zero_0 = 0; eng_write_0 = 0; eng_addr_0 = 0; eng_wrdata_0 = 0;
        hb_req = 0; hb_we = 0; hb_addr = 0; hb_wdata = 0;
        repeat (3) tick();
        #1;
        chk("rst_ack",   hb_ack, 0);
        chk("rst_rdata", hb_rdata, 0);
        chk("rst_busy",  clr_busy, 0);
        chk("rst_ram",   {ram_read_0, ram_zero_0, ram_write_0}, 0);
        tick();
        rst = 1'b0;

        eng_wr(8'h12, 16'hBEEF);
        eng_wr(8'h40, 16'h1234);
        eng_wr(8'h50, 16'hCAFE);

        // Host read, engine idle.
        tick();
        hb_req = 1; hb_we = 0; hb_addr = 8'h12;
        #1;
        chk("t1_issue", {ram_read_0, ram_write_0, ram_addr_0}, {1'b1, 1'b0, 8'h12});
        for (int k = 1; k <= 3; k++) begin
            tick(); #1;
            chk("t1_wait", {hb_ack, ram_read_0}, 0);
        end
        tick(); #1;
        chk("t1_ack",   hb_ack, 1);
        chk("t1_rdata", hb_rdata, 16'hBEEF);
        tick();
        hb_req = 0;
        #1;
        chk("t1_ack_pulse", hb_ack, 0);

        // Host write blocked by a 3-cycle engine read burst.
        tick();
        eng_read_0 = 1; eng_addr_0 = 8'h40;
        hb_req = 1; hb_we = 1; hb_addr = 8'h31; hb_wdata = 16'h5A5A;
        #1;
        chk("t2_eng_first", {ram_read_0, ram_write_0, ram_addr_0}, {1'b1, 1'b0, 8'h40});
        for (int k = 1; k <= 2; k++) begin
            tick(); #1;
            chk("t2_host_held", {ram_write_0, hb_ack}, 0);
        end
        tick();
        eng_read_0 = 0;
        #1;
        chk("t2_host_issue", {ram_write_0, ram_read_0, ram_addr_0, ram_wrdata_0},
            {1'b1, 1'b0, 8'h31, 16'h5A5A});
        chk("t2_eng_data", eng_rddata_3, 16'h1234);
        tick(); #1;
        chk("t2_ack", hb_ack, 1);
        chk("t2_rdata_hold", hb_rdata, 16'hBEEF);
        tick();
        hb_req = 0; hb_we = 0;
        #1;
        chk("t2_mem", mem[8'h31], 16'h5A5A);

        // Host read at T with an engine read at T+1; data streams must not cross.
        tick();
        hb_req = 1; hb_we = 0; hb_addr = 8'h31;
        #1;
        chk("t3_issue", {ram_read_0, ram_addr_0}, {1'b1, 8'h31});
        tick();
        eng_read_0 = 1; eng_addr_0 = 8'h40;
        #1;
        chk("t3_eng_fwd", {ram_read_0, ram_addr_0}, {1'b1, 8'h40});
        tick();
        eng_read_0 = 0;
        tick();
        #1;
        chk("t3_eng_sees_host_slot", {hb_ack, eng_rddata_3}, {1'b0, 16'h5A5A});
        tick(); #1;
        chk("t3_eng_data", eng_rddata_3, 16'h1234);
        chk("t3_ack",      hb_ack, 1);
        chk("t3_rdata",    hb_rdata, 16'h5A5A);
        tick();
        hb_req = 0;

        // Reset one cycle after a host read issues: no ack, then normal service.
        tick();
        hb_req = 1; hb_we = 0; hb_addr = 8'h50;
        tick();
        rst = 1; hb_req = 0;
        tick();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk("t4_no_ack", hb_ack, 0);
        end
        chk("t4_rdata_rst", hb_rdata, 0);
        host_rd(8'h50, d, lat);
        chk("t4_lat",   lat, 4);
        chk("t4_rdata", d, 16'hCAFE);

        // Engine zero command passes straight through.
        tick();
        eng_zero_0 = 1; eng_addr_0 = 8'h12;
        #1;
        chk("zero_fwd", {ram_zero_0, ram_read_0, ram_write_0, ram_addr_0}, {3'b100, 8'h12});
        tick();
        eng_zero_0 = 0;
        host_rd(8'h12, d, lat);
        chk("zero_rd", d, 16'h0000);

`ifdef USB_EPS_ARB_CLEAR_EN
        begin
            int cnt, nwr, nz, c, ack_c, fall, viol;
            logic seen;
            for (int a = 0; a < 256; a++) eng_wr(8'(a), 16'hFFFF);
            tick();
            clr_req = 1;
            tick();
            clr_req = 0;
            #1;
            chk("t5_busy_set", clr_busy, 1);
            cnt = 1; nwr = 0;
            while (clr_busy && cnt < 300) begin
                if (ram_write_0 && ram_wrdata_0 == 16'h0) nwr++;
                tick(); #1;
                cnt++;
            end
            chk("t5_done_cycle", cnt, 257);
            chk("t5_writes",     nwr, 256);
            tick();
            nz = 0;
            for (int a = 0; a < 256; a++) if (mem[a] != 16'h0) nz++;
            chk("t5_all_zero", nz, 0);

            eng_wr(8'h05, 16'h7777);
            ack_c = -1; fall = -1; viol = 0; seen = 0; d = 16'hFFFF;
            for (c = 0; c < 700 && !(ack_c >= 0 && c > ack_c + 1); c++) begin
                tick();
                clr_req    = (c == 0);
                eng_read_0 = (c > 0) && ((c % 20) < 3);
                eng_addr_0 = 8'h40;
                hb_req     = (c >= 2) && (ack_c < 0);
                hb_we      = 0;
                hb_addr    = 8'h05;
                #1;
                if (eng_read_0 && ram_write_0) viol++;
                if (clr_busy) seen = 1;
                if (seen && !clr_busy && fall < 0) fall = c;
                if (hb_ack) begin ack_c = c; d = hb_rdata; end
            end
            eng_read_0 = 0; hb_req = 0; clr_req = 0;
            chk("t6_acked",    ack_c >= 0, 1);
            chk("t6_order",    (fall >= 0) && (ack_c > fall), 1);
            chk("t6_paused",   fall > 257, 1);
            chk("t6_no_clash", viol, 0);
            chk("t6_rdata",    d, 16'h0000);
        end
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
